// File: rtl/dma_wave_if.sv
// Memory-read request bus between dma_wave (master) and sequencer slot 3 (slave).
interface dma_wave_if;
    logic        dma_req;
    logic [21:0] dma_addr;
    logic        dma_rnw;
    logic        dma_ack;
    logic        dma_end;
    logic [7:0]  dma_rd;

    modport master (output dma_req, dma_addr, dma_rnw, input dma_ack, dma_end, dma_rd);
    modport slave  (input dma_req, dma_addr, dma_rnw, output dma_ack, dma_end, dma_rd);
endinterface

// File: rtl/dma_wave.sv
// Sample-streaming DMA: reads bytes from memory into a 4-entry FIFO for the sound consumer.
// Define DMA_WAVE_INT_EN to pulse int_req after each 512-byte block is requested.
module dma_wave (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       module_select,
    input  logic       write_strobe,
    input  logic [1:0] regsel,
    input  logic [7:0] din,
    output logic [7:0] dout,
    dma_wave_if.master dma,
    output logic [7:0] smp_data,
    output logic       smp_valid,
    input  logic       smp_rd,
    output logic       int_req
);
    logic [21:0] base_q, base_d, ptr_q, ptr_d;
    logic [2:0]  pend_q, pend_d, cnt_q, cnt_d, cnt_base;
    logic [1:0]  rd_q, rd_d, wr_q, wr_d, wr_idx;
    logic        busy_q, busy_d, unr_q, unr_d, int_q, int_d;
    logic [7:0]  fifo_q [4];
    logic [3:0]  inflight;
    logic        req, reg_wr, start, stop, ack_fire, end_fire, pop;

    // Reserving FIFO space for every accepted request keeps count + pending <= 4.
    assign inflight     = {1'b0, cnt_q} + {1'b0, pend_q};
    assign req          = busy_q && (inflight < 4'd4);
    assign dma.dma_req  = req;
    assign dma.dma_addr = ptr_q;
    assign dma.dma_rnw  = 1'b1;
    assign smp_valid    = (cnt_q != 3'd0);
    assign smp_data     = fifo_q[rd_q];
    assign int_req      = int_q;

    assign reg_wr   = module_select & write_strobe;
    assign start    = reg_wr && (regsel == 2'd3) && din[0];
    assign stop     = reg_wr && (regsel == 2'd3) && din[1] && !din[0];
    assign ack_fire = req & dma.dma_ack;
    assign end_fire = dma.dma_end && (pend_q != 3'd0);
    assign pop      = smp_rd && smp_valid;

`ifdef DMA_WAVE_INT_EN
    assign int_d = ack_fire && (ptr_q[8:0] == 9'h1FF);
`else
    assign int_d = 1'b0;
`endif

    always_comb begin
        case (regsel)
            2'd0:    dout = base_q[7:0];
            2'd1:    dout = base_q[15:8];
            2'd2:    dout = {2'b00, base_q[21:16]};
            default: dout = {busy_q, unr_q, 3'b000, cnt_q};
        endcase
    end

    always_comb begin
        base_d   = base_q;
        ptr_d    = ptr_q;
        busy_d   = busy_q;
        unr_d    = unr_q;
        rd_d     = rd_q;
        wr_idx   = wr_q;
        cnt_base = cnt_q;
        if (reg_wr) begin
            case (regsel)
                2'd0:    base_d[7:0]   = din;
                2'd1:    base_d[15:8]  = din;
                2'd2:    base_d[21:16] = din[5:0];
                default: ;
            endcase
        end
        if (ack_fire)
            ptr_d = ptr_q + 22'd1;
        // A start flushes first, so an end landing in the same cycle is the first entry.
        if (start) begin
            ptr_d    = base_q;
            busy_d   = 1'b1;
            unr_d    = 1'b0;
            rd_d     = '0;
            wr_idx   = '0;
            cnt_base = '0;
        end else begin
            if (stop)
                busy_d = 1'b0;
            if (pop) begin
                rd_d     = rd_q + 2'd1;
                cnt_base = cnt_q - 3'd1;
            end else if (smp_rd) begin
                unr_d = 1'b1;
            end
        end
        wr_d  = wr_idx;
        cnt_d = cnt_base;
        if (end_fire) begin
            wr_d  = wr_idx + 2'd1;
            cnt_d = cnt_base + 3'd1;
        end
        pend_d = pend_q;
        if (ack_fire && !end_fire)
            pend_d = pend_q + 3'd1;
        else if (!ack_fire && end_fire)
            pend_d = pend_q - 3'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            ptr_q  <= '0;
            pend_q <= '0;
            cnt_q  <= '0;
            rd_q   <= '0;
            wr_q   <= '0;
            busy_q <= 1'b0;
            unr_q  <= 1'b0;
            int_q  <= 1'b0;
        end else begin
            base_q <= base_d;
            ptr_q  <= ptr_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            busy_q <= busy_d;
            unr_q  <= unr_d;
            int_q  <= int_d;
        end
    end

    always_ff @(posedge clk) begin
        if (end_fire)
            fifo_q[wr_idx] <= dma.dma_rd;
    end
endmodule

// File: tb/tb_dma_wave.sv
// Bench for dma_wave: directed scenarios then randomized traffic against a queue-based model.
module tb_dma_wave;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       module_select = 1'b0;
    logic       write_strobe = 1'b0;
    logic [1:0] regsel = 2'd0;
    logic [7:0] din = 8'd0;
    logic [7:0] dout;
    logic [7:0] smp_data;
    logic       smp_valid;
    logic       smp_rd = 1'b0;
    logic       int_req;

    dma_wave_if dif();

    dma_wave dut (
        .clk(clk), .rst_n(rst_n), .module_select(module_select),
        .write_strobe(write_strobe), .regsel(regsel), .din(din), .dout(dout),
        .dma(dif), .smp_data(smp_data), .smp_valid(smp_valid),
        .smp_rd(smp_rd), .int_req(int_req)
    );

    always #5 clk = ~clk;

    typedef struct { logic [21:0] addr; int due; } xfer_t;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          ack_pct = 100, lat_min = 1, lat_max = 1, ack_budget = -1, spur_pct = 0;
    int          int_seen = 0;
    logic [7:0]  key;
    xfer_t       lat_q[$];
    logic [21:0] acked[$];
    logic [7:0]  m_fifo[$];
    logic [21:0] m_base, m_ptr;
    int          m_pend;
    bit          m_busy, m_unr, m_int;

    function automatic logic [7:0] mem(input logic [21:0] a);
        return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ key;
    endfunction

    function automatic bit m_req();
        return m_busy && ((m_fifo.size() + m_pend) < 4);
    endfunction

    function automatic logic [7:0] m_status();
        return {m_busy, m_unr, 3'b000, 3'(m_fifo.size())};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] sel, input logic [7:0] exp);
        regsel = sel;
        #1;
        chk(tag, dout, exp);
    endtask

    // One clock: responder decisions, edge, model update, output checks.
    task automatic step();
        bit         do_ack, do_end, end_eff, wr, start_s, stop_s, rd_s;
        logic [1:0] sel;
        logic [7:0] d, rdv;
        do_ack = 0; do_end = 0; rdv = 8'd0;
        if (lat_q.size() > 0) begin
            if (lat_q[0].due <= cyc) begin
                do_end = 1;
                rdv = mem(lat_q[0].addr);
                void'(lat_q.pop_front());
            end
        end else if (spur_pct > 0 && $urandom_range(0, 99) < spur_pct) begin
            do_end = 1;
            rdv = 8'($urandom);
        end
        if (m_req() && ack_budget != 0 && $urandom_range(0, 99) < ack_pct) begin
            do_ack = 1;
            if (ack_budget > 0) ack_budget--;
            chk("ack_addr", dif.dma_addr, m_ptr);
            acked.push_back(m_ptr);
            lat_q.push_back('{m_ptr, cyc + $urandom_range(lat_min, lat_max)});
        end
        if (smp_rd && m_fifo.size() > 0) chk("pop_data", smp_data, m_fifo[0]);
        dif.dma_ack = do_ack;
        dif.dma_end = do_end;
        dif.dma_rd  = rdv;
        wr = module_select && write_strobe;
        sel = regsel; d = din; rd_s = smp_rd;
        start_s = wr && sel == 2'd3 && d[0];
        stop_s  = wr && sel == 2'd3 && d[1] && !d[0];

        @(posedge clk);
        cyc++;
        end_eff = do_end && (m_pend > 0);
        m_int = 0;
        if (do_ack) begin
`ifdef DMA_WAVE_INT_EN
            m_int = (m_ptr[8:0] == 9'h1FF);
`endif
            m_ptr = m_ptr + 22'd1;
            m_pend++;
        end
        if (end_eff) m_pend--;
        if (wr) begin
            case (sel)
                2'd0: m_base[7:0]   = d;
                2'd1: m_base[15:8]  = d;
                2'd2: m_base[21:16] = d[5:0];
                default: ;
            endcase
        end
        if (start_s) begin
            m_ptr = m_base; m_fifo.delete(); m_unr = 0; m_busy = 1;
        end else begin
            if (stop_s) m_busy = 0;
            if (rd_s) begin
                if (m_fifo.size() > 0) void'(m_fifo.pop_front());
                else m_unr = 1;
            end
        end
        if (end_eff) m_fifo.push_back(rdv);

        #1;
        module_select = 0; write_strobe = 0; smp_rd = 0;
        dif.dma_ack = 0; dif.dma_end = 0;
        if (int_req === 1'b1) int_seen++;
        chk("req", dif.dma_req, m_req());
        if (m_req()) chk("addr", dif.dma_addr, m_ptr);
        chk("valid", smp_valid, m_fifo.size() != 0);
        if (m_fifo.size() > 0) chk("head", smp_data, m_fifo[0]);
        chk("int", int_req, m_int);
        chk("rnw", dif.dma_rnw, 1'b1);
    endtask

    task automatic wr_reg(input logic [1:0] sel, input logic [7:0] val);
        module_select = 1; write_strobe = 1; regsel = sel; din = val;
        step();
    endtask

    task automatic set_base(input logic [21:0] b);
        wr_reg(2'd0, b[7:0]);
        wr_reg(2'd1, b[15:8]);
        wr_reg(2'd2, {2'($urandom), b[21:16]});
    endtask

    task automatic do_reset();
        rst_n = 0; smp_rd = 0; write_strobe = 0; module_select = 0;
        dif.dma_ack = 0; dif.dma_end = 0;
        m_base = '0; m_ptr = '0; m_pend = 0; m_fifo.delete();
        m_busy = 0; m_unr = 0; m_int = 0;
        repeat (2) begin @(posedge clk); cyc++; end
        #1;
        chk("rst_req", dif.dma_req, 1'b0);
        chk("rst_valid", smp_valid, 1'b0);
        chk("rst_int", int_req, 1'b0);
        chk("rst_rnw", dif.dma_rnw, 1'b1);
        rd_chk("rst_status", 2'd3, 8'h00);
        rd_chk("rst_base0", 2'd0, 8'h00);
        rst_n = 1;
    endtask

    initial begin
        key = 8'($urandom);
        dif.dma_ack = 0; dif.dma_end = 0; dif.dma_rd = 8'd0;
        do_reset();

        // Unstalled fill from 012345
        set_base(22'h012345);
        rd_chk("base_rb2", 2'd2, 8'h01);
        acked.delete();
        wr_reg(2'd3, 8'h01);
        repeat (8) step();
        chk("fill_nacks", acked.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < acked.size()) chk("fill_addr", acked[i], 22'h012345 + 22'(i));
        chk("fill_req_low", dif.dma_req, 1'b0);
        chk("fill_valid", smp_valid, 1'b1);
        rd_chk("fill_status", 2'd3, 8'h84);

        // One pop frees a slot; pops return data in write order
        chk("pop_first", smp_data, mem(22'h012345));
        smp_rd = 1;
        step();
        repeat (2) step();
        chk("refill_nacks", acked.size(), 5);
        if (acked.size() == 5) chk("refill_addr", acked[4], 22'h012349);
        for (int i = 1; i < 5; i++) begin
            chk("pop_order", smp_data, mem(22'h012345 + 22'(i)));
            smp_rd = 1;
            step();
        end
        wr_reg(2'd3, 8'h02);
        repeat (6) step();

        // Pointer wraps at 22 bits
        set_base(22'h3FFFFE);
        acked.delete();
        wr_reg(2'd3, 8'h01);
        repeat (6) step();
        chk("wrap_nacks", acked.size(), 4);
        if (acked.size() >= 3) begin
            chk("wrap_a0", acked[0], 22'h3FFFFE);
            chk("wrap_a1", acked[1], 22'h3FFFFF);
            chk("wrap_a2", acked[2], 22'h000000);
        end
        wr_reg(2'd3, 8'h02);
        repeat (6) step();

        // Block-done interrupt
        set_base(22'h0001FE);
        int_seen = 0;
        wr_reg(2'd3, 8'h01);
        repeat (8) step();
`ifdef DMA_WAVE_INT_EN
        chk("int_pulses", int_seen, 1);
`else
        chk("int_pulses", int_seen, 0);
`endif
        wr_reg(2'd3, 8'h02);
        repeat (6) step();

        // Stop with two requests accepted but not yet completed
        lat_min = 6; lat_max = 6; ack_budget = 2;
        wr_reg(2'd3, 8'h01);
        repeat (3) step();
        rd_chk("stop_pre", 2'd3, 8'h80);
        wr_reg(2'd3, 8'h02);
        ack_budget = -1;
        repeat (8) step();
        rd_chk("stop_status", 2'd3, 8'h02);
        chk("stop_req", dif.dma_req, 1'b0);

        // Underrun is sticky until the next start
        lat_min = 1; lat_max = 1;
        repeat (2) begin smp_rd = 1; step(); end
        smp_rd = 1;
        step();
        rd_chk("unr_set", 2'd3, 8'h40);
        repeat (3) step();
        rd_chk("unr_hold", 2'd3, 8'h40);
        wr_reg(2'd3, 8'h01);
        rd_chk("unr_clr", 2'd3, 8'h80);
        wr_reg(2'd3, 8'h02);
        repeat (6) step();

        // Randomized traffic
        lat_min = 1; lat_max = 4; spur_pct = 5;
        for (int k = 0; k < 1500; k++) begin
            int r;
            if (k % 100 == 0) ack_pct = $urandom_range(30, 100);
            r = $urandom_range(0, 199);
            if (r < 4) begin
                logic [1:0] s;
                logic [7:0] v;
                s = 2'($urandom_range(0, 2));
                v = 8'($urandom);
                wr_reg(s, v);
                rd_chk("base_rb", s, (s == 2'd2) ? {2'b00, v[5:0]} : v);
            end else if (r < 10) begin
                wr_reg(2'd3, 8'h01);
            end else if (r < 13) begin
                wr_reg(2'd3, 8'h02);
            end else if (r == 13) begin
                do_reset();
            end else begin
                smp_rd = ($urandom_range(0, 99) < 40);
                step();
            end
            if (k % 50 == 0) rd_chk("status", 2'd3, m_status());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dma_wave.md
DMA_WAVE -- requirements
Module: dma_wave

Interface
REQ-001 SHALL have clk, input, 1, system clock (the Z80 clock domain); all logic is clocked on its rising edge.
REQ-002 SHALL have rst_n, input, 1, reset; one clock, and reset is asynchronous and active-low.
REQ-003 SHALL have module_select, input, 1: register access targets this block.
REQ-004 SHALL have write_strobe, input, 1: one-cycle register write pulse.
REQ-005 SHALL have regsel, input, 2: register index.
REQ-006 SHALL have din, input, 8: register write data.
REQ-007 SHALL have dout, output, 8: register read data (combinational from regsel).
REQ-008 SHALL have dma_req, output, 1: memory-read request to sequencer slot 3.
REQ-009 SHALL have dma_addr, output, 22: request address.
REQ-010 SHALL have dma_rnw, output, 1: constant 1 (read only).
REQ-011 SHALL have dma_ack, input, 1: request accepted.
REQ-012 SHALL have dma_end, input, 1: read data valid on dma_rd.
REQ-013 SHALL have dma_rd, input, 8: read data.
REQ-014 SHALL have smp_data, output, 8: FIFO head sample.
REQ-015 SHALL have smp_valid, output, 1: FIFO not empty.
REQ-016 SHALL have smp_rd, input, 1: one-cycle pop strobe from sound consumer.
REQ-017 SHALL have int_req, output, 1: one-cycle block-done pulse.

Function
REQ-018 SHALL write a register when module_select & write_strobe: regsel 0/1/2 = base[7:0]/[15:8]/[21:16] (din[5:0]); 3 = control (bit0 start, bit1 stop).
REQ-019 SHALL read back: regsel 0-2 = base bytes, upper bits of reg 2 zero; 3 = {busy, underrun, 3'b0, fifo count[2:0]}.
REQ-020 SHALL, on start, load the pointer from base, flush the FIFO, clear underrun and set busy; start while busy restarts.
REQ-021 SHALL hold dma_req high with dma_addr = pointer while busy and (count + pending) < 4; addr stable until dma_ack.
REQ-022 SHALL, on dma_ack, increment the pointer (22-bit wrap 3FFFFF->0) and the pending counter; dma_req may re-assert in the next cycle.
REQ-023 SHALL, on dma_end, decrement pending and push dma_rd into a 4-entry FIFO.
REQ-024 SHALL pop on smp_rd when smp_valid; push and pop in the same cycle leave count unchanged.
REQ-025 SHALL ignore smp_rd when empty and set sticky underrun.
REQ-026 SHALL, on stop, clear busy and drop dma_req next cycle; outstanding ends still complete and are pushed; FIFO is kept.
REQ-027 SHALL ignore dma_end when pending is 0.
REQ-028 SHALL never overflow: count + pending <= 4 always.

Reset
REQ-029 SHALL on rst_n low: base, pointer, pending and count = 0; busy = 0; underrun = 0; dma_req = 0; int_req = 0; smp_valid = 0; dma_rnw = 1.
REQ-030 SHALL abandon outstanding transfers on reset; no push after reset deasserts for a pre-reset ack.

Configuration
REQ-031 SHALL, with DMA_WAVE_INT_EN defined, pulse int_req for one cycle on the dma_ack whose address has [8:0] = 9'h1FF (each 512-byte block done).
REQ-032 SHALL, without DMA_WAVE_INT_EN, tie int_req to 0; all other behaviour is unchanged.

Verification
REQ-033 SHALL cover: base=012345, start, ack/end with no stall -> 4 requests at 012345..012348, dma_req low, smp_valid=1, count=4.
REQ-034 SHALL cover: full FIFO, smp_rd once -> next request at 012349 issued within 2 cycles; data pops in write order.
REQ-035 SHALL cover: base=3FFFFE, start -> addresses 3FFFFE, 3FFFFF, 000000.
REQ-036 SHALL cover: macro on, base=0001FE -> int_req single pulse at ack of 0001FF; macro off -> int_req stays 0.
REQ-037 SHALL cover: stop with 2 acked but not ended -> both ends pushed, count reaches 2, no further dma_req.
REQ-038 SHALL cover: smp_rd on empty FIFO -> underrun bit 6 reads 1 and stays set until the next start.
